// File: rtl/slope_integ_if.sv
// ---------------------------------------------------------------------------
// slope_integ_if
// Control/data bundle for the slope integrator.
//   master : drives read_en, start, stop, mode, step_i, init_i, lim_hi,
//            lim_lo; observes dat_o, running, at_limit.
//   slave  : the integrator itself (mirror image of master).
// R must match the R parameter of the slope_integ instance on the slave side.
// ---------------------------------------------------------------------------
interface slope_integ_if #(
   parameter int R = 15
);
   logic                read_en;   // sample strobe
   logic                start;     // load init_i, enter RUN
   logic                stop;      // enter IDLE, freeze output
   logic                mode;      // 0 = clamp, 1 = bounce
   logic signed [R-1:0] step_i;    // step per strobe, 2^-F output LSB units
   logic signed [R-1:0] init_i;    // start value
   logic signed [R-1:0] lim_hi;    // upper limit
   logic signed [R-1:0] lim_lo;    // lower limit
   logic signed [R-1:0] dat_o;     // integrated output
   logic                running;   // high in RUN
   logic                at_limit;  // LIMIT level / reversal pulse

   modport master (
      output read_en, start, stop, mode, step_i, init_i, lim_hi, lim_lo,
      input  dat_o, running, at_limit
   );

   modport slave (
      input  read_en, start, stop, mode, step_i, init_i, lim_hi, lim_lo,
      output dat_o, running, at_limit
   );
endinterface

// File: rtl/slope_integ.sv
// ---------------------------------------------------------------------------
// slope_integ
// Integrates a signed per-sample slope into a ramp or triangle output. A
// fixed-point accumulator (R integer + F fractional bits) advances by step_i
// on every read_en strobe while in RUN, bounded by lim_lo/lim_hi with either
// a clamp-and-stop (mode 0) or bounce (mode 1) policy.
//
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - slope_integ_if.slave: read_en, start, stop, mode, step_i, init_i,
//          lim_hi, lim_lo in; dat_o, running, at_limit out (all registered)
//
// Build option:
//   SLOPE_INTEG_ROUND_EN - when defined, dat_o is rounded half-up from the
//   accumulator (saturating at the positive maximum) instead of truncated.
//   Limit checks always use the full accumulator.
// ---------------------------------------------------------------------------
module slope_integ #(
   parameter int R = 15,
   parameter int F = 6
) (
   input  logic          clk,
   input  logic          rst,
   slope_integ_if.slave  bus
);

   localparam int W = R + F;      // accumulator width
   localparam int X = R + F + 2;  // headroom width for the next-value sum

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      LIMIT
   } state_t;

   state_t              state;
   logic signed [W-1:0] acc;
   logic                descending;  // 1 = subtracting step_i (dir = -1)

   logic signed [X-1:0] acc_x;
   logic signed [X-1:0] step_x;
   logic signed [X-1:0] hi_x;
   logic signed [X-1:0] lo_x;
   logic signed [X-1:0] nxt;
   logic signed [R-1:0] init_clamped;
   logic                lim_bad;

   // Output view of an accumulator value.
   function automatic logic signed [R-1:0] to_out(input logic signed [W-1:0] a);
`ifdef SLOPE_INTEG_ROUND_EN
      // Rounding can only add one, so the sole overflow case is the
      // positive maximum with the half bit set.
      if (a[W-1:F] == {1'b0, {(R-1){1'b1}}})
         return a[W-1:F];
      else
         return a[W-1:F] + {{(R-1){1'b0}}, a[F-1]};
`else
      return a[W-1:F];
`endif
   endfunction

   // Limit value placed on the accumulator grid.
   function automatic logic signed [W-1:0] on_grid(input logic signed [R-1:0] v);
      return {v, {F{1'b0}}};
   endfunction

   // NOTE: every variable written here gets a value on all paths first, so no
   // latch can be inferred.
   always_comb begin
      acc_x   = {{2{acc[W-1]}}, acc};
      step_x  = {{(F+2){bus.step_i[R-1]}}, bus.step_i};
      hi_x    = {{2{bus.lim_hi[R-1]}}, bus.lim_hi, {F{1'b0}}};
      lo_x    = {{2{bus.lim_lo[R-1]}}, bus.lim_lo, {F{1'b0}}};
      // Two extra bits mean the sum cannot wrap before the limit compare.
      nxt     = descending ? (acc_x - step_x) : (acc_x + step_x);
      lim_bad = (bus.lim_lo > bus.lim_hi);

      // clamp = max(lo, min(init, hi)); the lower limit wins if inverted.
      init_clamped = bus.init_i;
      if (init_clamped > bus.lim_hi)
         init_clamped = bus.lim_hi;
      if (init_clamped < bus.lim_lo)
         init_clamped = bus.lim_lo;
   end

   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         acc          <= '0;
         descending   <= 1'b0;
         bus.dat_o    <= '0;
         bus.running  <= 1'b0;
         bus.at_limit <= 1'b0;
      end else if (bus.stop) begin
         // Freeze: acc and dat_o keep their values.
         state        <= IDLE;
         bus.running  <= 1'b0;
         bus.at_limit <= 1'b0;
      end else if (bus.start) begin
         // Any read_en in this cycle is deliberately ignored.
         state        <= RUN;
         acc          <= on_grid(init_clamped);
         bus.dat_o    <= to_out(on_grid(init_clamped));
         descending   <= 1'b0;
         bus.running  <= 1'b1;
         bus.at_limit <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.running  <= 1'b0;
               bus.at_limit <= 1'b0;
            end

            RUN: begin
               bus.at_limit <= 1'b0;  // reversal pulse lasts one clk
               if (bus.read_en) begin
                  if (lim_bad) begin
                     // Inverted limits stop the ramp whatever the mode.
                     state        <= LIMIT;
                     acc          <= on_grid(bus.lim_lo);
                     bus.dat_o    <= to_out(on_grid(bus.lim_lo));
                     bus.running  <= 1'b0;
                     bus.at_limit <= 1'b1;
                  end else if (nxt > hi_x) begin
                     acc          <= on_grid(bus.lim_hi);
                     bus.dat_o    <= to_out(on_grid(bus.lim_hi));
                     bus.at_limit <= 1'b1;
                     if (bus.mode) begin
                        descending <= 1'b1;
                     end else begin
                        state       <= LIMIT;
                        bus.running <= 1'b0;
                     end
                  end else if (nxt < lo_x) begin
                     acc          <= on_grid(bus.lim_lo);
                     bus.dat_o    <= to_out(on_grid(bus.lim_lo));
                     bus.at_limit <= 1'b1;
                     if (bus.mode) begin
                        descending <= 1'b0;
                     end else begin
                        state       <= LIMIT;
                        bus.running <= 1'b0;
                     end
                  end else begin
                     // In range, so the low W bits hold the exact value.
                     acc       <= nxt[W-1:0];
                     bus.dat_o <= to_out(nxt[W-1:0]);
                  end
               end
            end

            LIMIT: begin
               bus.running  <= 1'b0;
               bus.at_limit <= 1'b1;
            end

            default: begin
               state        <= IDLE;
               bus.running  <= 1'b0;
               bus.at_limit <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_slope_integ.sv
// ---------------------------------------------------------------------------
// tb_slope_integ
// Directed self-checking bench for slope_integ. Inputs change 1 ns after the
// rising edge; outputs are sampled at that same point, so every check sees
// the result of the preceding edge.
// ---------------------------------------------------------------------------
module tb_slope_integ;

   localparam int R = 15;
   localparam int F = 6;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   slope_integ_if #(.R(R)) bus ();

   slope_integ #(.R(R), .F(F)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
   endtask

   task automatic strobe();
      bus.read_en = 1'b1;
      tick();
      bus.read_en = 1'b0;
   endtask

   int exp_frac [3];
   int exp_neg;
   int exp_bounce [7];
   int exp_pulse  [7];

   initial begin
      exp_bounce = '{10, 7, 4, 1, 0, 3, 6};
      exp_pulse  = '{1, 0, 0, 0, 1, 0, 0};
`ifdef SLOPE_INTEG_ROUND_EN
      exp_frac = '{1, 1, 2};
      exp_neg  = 0;
`else
      exp_frac = '{0, 1, 1};
      exp_neg  = -1;
`endif

      // ---- reset with noisy inputs --------------------------------------
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.read_en = 1'b1;
         bus.start   = 1'($urandom_range(0, 1));
         bus.stop    = 1'($urandom_range(0, 1));
         bus.mode    = 1'($urandom_range(0, 1));
         bus.step_i  = 15'($urandom);
         bus.init_i  = 15'($urandom);
         bus.lim_hi  = 15'($urandom);
         bus.lim_lo  = 15'($urandom);
         tick();
         check("rst_dat", bus.dat_o, 0);
         check("rst_running", bus.running, 0);
         check("rst_at_limit", bus.at_limit, 0);
      end
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.read_en = 1'b1;
      repeat (4) tick();
      check("idle_dat", bus.dat_o, 0);
      check("idle_running", bus.running, 0);
      bus.read_en = 1'b0;

      // ---- linear ramp, mode 0 ------------------------------------------
      bus.mode   = 1'b0;
      bus.lim_hi = 15'sd1000;
      bus.lim_lo = -15'sd1000;
      bus.init_i = 15'sd100;
      bus.step_i = 15'sd64;
      pulse_start();
      check("ramp_init", bus.dat_o, 100);
      check("ramp_running0", bus.running, 1);
      bus.read_en = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         check($sformatf("ramp_%0d", i), bus.dat_o, 100 + i);
      end
      bus.read_en = 1'b0;
      check("ramp_running", bus.running, 1);
      pulse_stop();
      check("stop_dat", bus.dat_o, 110);
      check("stop_running", bus.running, 0);
      strobe();
      check("stop_hold", bus.dat_o, 110);

      // ---- fractional step ----------------------------------------------
      bus.init_i = 15'sd0;
      bus.step_i = 15'sd32;
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         strobe();
         check($sformatf("frac_%0d", i), bus.dat_o, exp_frac[i]);
      end
      bus.step_i = -15'sd32;
      pulse_start();
      strobe();
      check("frac_neg", bus.dat_o, exp_neg);

      // ---- clamp, mode 0 ------------------------------------------------
      bus.init_i = 15'sd990;
      bus.step_i = 15'sd640;
      pulse_start();
      strobe();  // lands exactly on lim_hi: not an overshoot
      check("clamp_exact_dat", bus.dat_o, 1000);
      check("clamp_exact_run", bus.running, 1);
      check("clamp_exact_lim", bus.at_limit, 0);
      strobe();  // overshoot -> LIMIT
      check("clamp_dat", bus.dat_o, 1000);
      check("clamp_running", bus.running, 0);
      check("clamp_at_limit", bus.at_limit, 1);
      repeat (5) strobe();
      check("clamp_hold_dat", bus.dat_o, 1000);
      check("clamp_hold_lim", bus.at_limit, 1);
      pulse_start();
      check("clamp_restart_dat", bus.dat_o, 990);
      check("clamp_restart_run", bus.running, 1);
      check("clamp_restart_lim", bus.at_limit, 0);

      // ---- bounce, mode 1 -----------------------------------------------
      bus.mode   = 1'b1;
      bus.lim_lo = 15'sd0;
      bus.lim_hi = 15'sd10;
      bus.init_i = 15'sd8;
      bus.step_i = 15'sd192;
      pulse_start();
      bus.read_en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         check($sformatf("bounce_dat_%0d", i), bus.dat_o, exp_bounce[i]);
         check($sformatf("bounce_lim_%0d", i), bus.at_limit, exp_pulse[i]);
         check($sformatf("bounce_run_%0d", i), bus.running, 1);
      end
      bus.read_en = 1'b0;
      tick();
      check("bounce_gap_lim", bus.at_limit, 0);
      check("bounce_gap_dat", bus.dat_o, 6);

      // ---- start and stop together -> IDLE ------------------------------
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      check("startstop_run", bus.running, 0);
      check("startstop_dat", bus.dat_o, 6);
      strobe();
      check("startstop_hold", bus.dat_o, 6);

      // ---- reset mid-RUN ------------------------------------------------
      bus.mode   = 1'b0;
      bus.lim_lo = -15'sd1000;
      bus.lim_hi = 15'sd1000;
      bus.init_i = 15'sd500;
      pulse_start();
      check("midrst_pre", bus.dat_o, 500);
      rst = 1'b1;
      bus.read_en = 1'b1;
      tick();
      rst = 1'b0;
      bus.read_en = 1'b0;
      check("midrst_dat", bus.dat_o, 0);
      check("midrst_run", bus.running, 0);

      // ---- inverted limits during RUN (mode 1) --------------------------
      bus.mode   = 1'b1;
      bus.lim_lo = 15'sd0;
      bus.lim_hi = 15'sd100;
      bus.init_i = 15'sd15;
      bus.step_i = 15'sd64;
      bus.read_en = 1'b1;  // ignored in the start cycle
      pulse_start();
      bus.read_en = 1'b0;
      check("inv_start_dat", bus.dat_o, 15);
      strobe();
      check("inv_step_dat", bus.dat_o, 16);
      bus.lim_lo = 15'sd20;
      bus.lim_hi = 15'sd10;
      tick();
      check("inv_nostrobe", bus.dat_o, 16);
      strobe();
      check("inv_dat", bus.dat_o, 20);
      check("inv_run", bus.running, 0);
      check("inv_lim", bus.at_limit, 1);

      // ---- top of range, no wrap ----------------------------------------
      bus.mode   = 1'b0;
      bus.lim_lo = -15'sd1000;
      bus.lim_hi = 15'h3FFF;
      bus.init_i = 15'h3FF0;
      bus.step_i = 15'h3FFF;
      pulse_start();
      check("top_init", bus.dat_o, 16368);
      strobe();
      check("top_dat", bus.dat_o, 16383);
      check("top_lim", bus.at_limit, 1);
      check("top_run", bus.running, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
